// File: rtl/decoder_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module      : decoder_cmd_frontend
// Description : Wishbone slave that queues 4-bit select codes in a FIFO and
//               drains them to the 4-to-16 decoder over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_cmd_frontend #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [3:0]  dec_code_o,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic        irq_o
);

    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] C_DEPTH    = 5'(DEPTH);
    localparam logic [7:0] C_OFF_CMD  = 8'h00;
    localparam logic [7:0] C_OFF_STAT = 8'h04;
    localparam logic [7:0] C_OFF_CTRL = 8'h08;

    logic          r_ack;
    logic [31:0]   r_dat;
    logic          r_drain_en;
    logic          r_irq_en;
    logic          r_overflow;
    logic          r_irq;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [4:0]    r_count;
    logic [3:0]    r_mem [DEPTH];

    logic          w_hit;
    logic          w_wr;
    logic          w_rd;
    logic [7:0]    w_off;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_flush;
    logic          w_ctrl_wr;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_full;
    logic          w_empty;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // The ~ack term spaces accepted transactions at least two cycles apart.
    assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
    assign w_off     = wbs_adr_i[7:0];
    assign w_wr      = w_hit & wbs_we_i;
    assign w_rd      = w_hit & ~wbs_we_i;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == 5'd0);

    assign w_push    = w_wr & (w_off == C_OFF_CMD) & wbs_sel_i[0];
    assign w_pop     = dec_valid_o & dec_ready_i;
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_ctrl_wr = w_wr & (w_off == C_OFF_CTRL) & wbs_sel_i[0];
    assign w_flush   = w_ctrl_wr & wbs_dat_i[2];
    assign w_ovf_set = w_push & ~w_push_ok;
    assign w_ovf_clr = w_wr & (w_off == C_OFF_STAT) & wbs_sel_i[1] & wbs_dat_i[10];

    assign w_unused  = ^{wbs_sel_i[3:2], wbs_dat_i[31:11], wbs_dat_i[9:4]};

    always_comb begin
        w_rdata = '0;
        case (w_off)
            C_OFF_STAT: w_rdata = {21'd0, r_overflow, w_empty, w_full, 3'd0, r_count};
            C_OFF_CTRL: w_rdata = {30'd0, r_irq_en, r_drain_en};
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_drain_en <= 1'b0;
            r_irq_en   <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_ack      <= w_hit;
            r_dat      <= w_rd ? w_rdata : 32'd0;
            r_overflow <= w_ovf_set | (r_overflow & ~w_ovf_clr);
            r_irq      <= r_irq_en & r_overflow;
            if (w_ctrl_wr) begin
                r_drain_en <= wbs_dat_i[0];
                r_irq_en   <= wbs_dat_i[1];
            end
            // Flush beats any push or pop landing on the same edge.
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + {4'd0, w_push_ok} - {4'd0, w_pop};
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push_ok && !w_flush)
            r_mem[r_wr_ptr] <= wbs_dat_i[3:0];
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign dec_valid_o = r_drain_en & ~w_empty;
    assign dec_code_o  = w_empty ? 4'd0 : r_mem[r_rd_ptr];
    assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_decoder_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_cmd_frontend
// Description : Scoreboard bench for decoder_cmd_frontend (bus reads + drain).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_cmd_frontend;

    localparam logic [31:0] C_BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat = 32'h0;
    logic        ready = 1'b0;
    logic        ack;
    logic [31:0] dat_o;
    logic [3:0]  code;
    logic        valid;
    logic        irq;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [3:0]  code_q[$];
    bus_exp_t    mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;

    decoder_cmd_frontend #(.DEPTH(8), .BASE_ADDR(C_BASE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .dec_code_o  (code),
        .dec_valid_o (valid),
        .dec_ready_i (ready),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the bus and decoder scoreboards whenever the DUT presents output.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
            end else begin
                mon_e = bus_q.pop_front();
                if (mon_e.is_read)
                    check("rd_data", dat_o, mon_e.exp);
            end
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            if (code_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got code 0x%0h expected no pop at %0t", code, $time);
            end else begin
                check("dec_code", {28'd0, code}, {28'd0, code_q.pop_front()});
            end
        end
    end

    task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit exp_ack, input logic [31:0] exp_rd);
        bit       got;
        bus_exp_t e;
        got = 1'b0;
        if (exp_ack) begin
            e.is_read = !w;
            e.exp     = exp_rd;
            bus_q.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n_checks++;
        if (exp_ack && !got) begin
            n_fail++;
            void'(bus_q.pop_back());
            $display("FAIL ack_timeout: got no ack expected ack adr=0x%08h", a);
        end else if (!exp_ack && got) begin
            n_fail++;
            $display("FAIL miss_acked: got ack expected none adr=0x%08h", a);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        bus(1'b1, C_BASE + {24'd0, off}, d, s, 1'b1, 32'd0);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        bus(1'b0, C_BASE + {24'd0, off}, 32'd0, 4'hF, 1'b1, exp);
    endtask

    task automatic pushc(input logic [3:0] c, input bit expect_drain);
        if (expect_drain) code_q.push_back(c);
        wr(8'h00, {28'd0, c}, 4'h1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_code", {28'd0, code}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        rd(8'h04, 32'h0000_0200);
        rd(8'h08, 32'h0);

        // Queue 3 codes, then drain them back to back
        ready = 1'b1;
        wr(8'h08, 32'h0, 4'h1);
        pushc(4'd3, 1'b1);
        pushc(4'd7, 1'b1);
        pushc(4'd15, 1'b1);
        rd(8'h04, 32'h0000_0003);
        wr(8'h08, 32'h1, 4'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("drain_valid", {31'd0, valid}, 32'd1);
        end
        @(negedge clk);
        check("drain_done", {31'd0, valid}, 32'd0);
        check("drain_len", 32'(code_q.size()), 32'd0);
        tick(1);

        // Overflow with 9 writes
        ready = 1'b0;
        wr(8'h08, 32'h2, 4'h1);
        for (int i = 1; i <= 9; i++)
            pushc(4'(i), i <= 8);
        rd(8'h04, 32'h0000_0508);
        check("irq_set", {31'd0, irq}, 32'd1);
        ready = 1'b1;
        wr(8'h08, 32'h3, 4'h1);
        tick(10);
        check("ovf_drain_len", 32'(code_q.size()), 32'd0);
        rd(8'h04, 32'h0000_0600);
        wr(8'h04, 32'h400, 4'h2);
        tick(1);
        check("irq_clr", {31'd0, irq}, 32'd0);
        rd(8'h04, 32'h0000_0200);

        // Full FIFO, push lands on a pop cycle; twice to exercise pointer wrap
        for (int it = 0; it < 2; it++) begin
            wr(8'h08, 32'h0, 4'h1);
            for (int i = 0; i < 8; i++)
                pushc(4'((i * 3 + it) & 15), 1'b1);
            rd(8'h04, 32'h0000_0108);
            wr(8'h08, 32'h1, 4'h1);
            pushc(4'(4'hA + it), 1'b1);
            tick(12);
            check("full_pop_len", 32'(code_q.size()), 32'd0);
            rd(8'h04, 32'h0000_0200);
        end

        // Reset with 4 queued entries and a write in flight
        ready = 1'b0;
        wr(8'h08, 32'h1, 4'h1);
        for (int i = 0; i < 4; i++)
            pushc(4'(i + 1), 1'b0);
        check("pre_rst_valid", {31'd0, valid}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = C_BASE; dat = 32'h5; sel = 4'h1;
        rst = 1'b1;
        tick(1);
        check("rst2_ack", {31'd0, ack}, 32'd0);
        check("rst2_valid", {31'd0, valid}, 32'd0);
        check("rst2_code", {28'd0, code}, 32'd0);
        check("rst2_irq", {31'd0, irq}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        tick(1);
        check("rst2_no_late_ack", {31'd0, ack}, 32'd0);
        rd(8'h04, 32'h0000_0200);
        rd(8'h08, 32'h0);

        // Miss address, sel without byte 0, unlisted offsets, flush
        ready = 1'b1;
        bus(1'b1, C_BASE + 32'h100, 32'h5, 4'h1, 1'b0, 32'd0);
        wr(8'h00, 32'h5, 4'b0010);
        rd(8'h04, 32'h0000_0200);
        rd(8'h00, 32'h0);
        wr(8'h10, 32'hFFFF_FFFF, 4'hF);
        rd(8'h10, 32'h0);
        pushc(4'd1, 1'b0);
        pushc(4'd2, 1'b0);
        rd(8'h04, 32'h0000_0002);
        wr(8'h08, 32'h4, 4'h1);
        rd(8'h04, 32'h0000_0200);
        rd(8'h08, 32'h0);
        check("flush_valid", {31'd0, valid}, 32'd0);

        tick(2);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
